// File: rtl/volatility_accum.sv
// Per-stock rolling-window accumulator. Each accepted sample replaces the
// price at its buffer address, updates that stock's running N, sum(p) and
// sum(p^2), and reports the unnormalised variance numerator N*sum(p^2)-sum(p)^2.
// The sample walks through a five-cycle FSM: IDLE -> LOAD -> ACC -> CALC -> OUT.
module volatility_accum #(
   parameter  int NUM_STOCKS  = 4,
   parameter  int BUFFER_SIZE = 20,
   parameter  int PRICE_WIDTH = 32,
   localparam int SID_W  = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
   localparam int DEPTH  = NUM_STOCKS * BUFFER_SIZE,
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W  = $clog2(BUFFER_SIZE + 1),
   localparam int SUM_W  = PRICE_WIDTH + CNT_W,
   localparam int SQ_W   = 2 * PRICE_WIDTH + CNT_W,
   localparam int VAR_W  = 2 * PRICE_WIDTH + 2 * CNT_W
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_addr_valid,
   input  logic [ADDR_W-1:0]      i_write_address,
   input  logic [SID_W-1:0]       i_stock_id,
   input  logic [PRICE_WIDTH-1:0] i_price,
   output logic                   o_ready,
   output logic                   o_valid,
   output logic [SID_W-1:0]       o_stock_id,
   output logic [CNT_W-1:0]       o_count,
   output logic [SUM_W-1:0]       o_sum,
   output logic [SQ_W-1:0]        o_sumsq,
   output logic [VAR_W-1:0]       o_var_num,
   output logic                   o_addr_error
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACC, S_CALC, S_OUT} state_t;

   state_t                 state_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [SID_W-1:0]       id_q;
   logic [PRICE_WIDTH-1:0] price_q;
   logic [PRICE_WIDTH-1:0] old_q;
   logic                   was_valid_q;

   // Entry-valid bits are what make an unreset RAM read as empty.
   logic [DEPTH-1:0]       vbit_q;
   logic [PRICE_WIDTH-1:0] mem [DEPTH];

   logic [CNT_W-1:0]       cnt_q   [NUM_STOCKS];
   logic [SUM_W-1:0]       sum_q   [NUM_STOCKS];
   logic [SQ_W-1:0]        sumsq_q [NUM_STOCKS];

   logic                   valid_q, err_q;
   logic [SID_W-1:0]       ostock_q;
   logic [CNT_W-1:0]       ocnt_q;
   logic [SUM_W-1:0]       osum_q;
   logic [SQ_W-1:0]        osq_q;
   logic [VAR_W-1:0]       ovar_q;

   logic                   accept;
   logic                   legal;
   logic [31:0]            base, addr_ext;
   logic [CNT_W-1:0]       cur_cnt, cnt_d;
   logic [SUM_W-1:0]       cur_sum, sum_d;
   logic [SQ_W-1:0]        cur_sq, sumsq_d;
   logic [VAR_W-1:0]       var_d;

   assign o_ready      = (state_q == S_IDLE);
   assign accept       = i_addr_valid && o_ready;
   assign o_valid      = valid_q;
   assign o_addr_error = err_q;
   assign o_stock_id   = ostock_q;
   assign o_count      = ocnt_q;
   assign o_sum        = osum_q;
   assign o_sumsq      = osq_q;
   assign o_var_num    = ovar_q;

   // Address must fall inside the requesting stock's own buffer region.
   always_comb begin
      base     = 32'(i_stock_id) * 32'(BUFFER_SIZE);
      addr_ext = 32'(i_write_address);
      legal    = (32'(i_stock_id) < 32'(NUM_STOCKS)) &&
                 (addr_ext >= base) &&
                 (addr_ext <= base + 32'(BUFFER_SIZE) - 32'd1);
   end

   // Accumulator update and variance numerator for the in-flight stock.
   // Eviction subtracts a value that was previously added, so no underflow.
   always_comb begin
      cur_cnt = cnt_q[id_q];
      cur_sum = sum_q[id_q];
      cur_sq  = sumsq_q[id_q];
      sum_d   = cur_sum + SUM_W'(price_q) - SUM_W'(old_q);
      sumsq_d = cur_sq + SQ_W'(price_q) * SQ_W'(price_q)
                       - SQ_W'(old_q) * SQ_W'(old_q);
      cnt_d   = (!was_valid_q && (cur_cnt < CNT_W'(BUFFER_SIZE)))
                ? cur_cnt + CNT_W'(1) : cur_cnt;
      // Cauchy-Schwarz keeps this non-negative.
      var_d   = VAR_W'(cur_cnt) * VAR_W'(cur_sq)
              - VAR_W'(cur_sum) * VAR_W'(cur_sum);
   end

   // Price RAM: not reset; writes only in ACC of an unreset cycle.
   always_ff @(posedge i_clk) begin
      if (!i_reset && state_q == S_ACC)
         mem[addr_q] <= price_q;
   end

   // Sequencing FSM with per-stock state and registered result outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         id_q        <= '0;
         price_q     <= '0;
         old_q       <= '0;
         was_valid_q <= 1'b0;
         vbit_q      <= '0;
         for (int s = 0; s < NUM_STOCKS; s++) begin
            cnt_q[s]   <= '0;
            sum_q[s]   <= '0;
            sumsq_q[s] <= '0;
         end
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         ostock_q <= '0;
         ocnt_q   <= '0;
         osum_q   <= '0;
         osq_q    <= '0;
         ovar_q   <= '0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (legal) begin
                     addr_q  <= i_write_address;
                     id_q    <= i_stock_id;
                     price_q <= i_price;
                     state_q <= S_LOAD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               old_q       <= vbit_q[addr_q] ? mem[addr_q] : '0;
               was_valid_q <= vbit_q[addr_q];
               state_q     <= S_ACC;
            end
            S_ACC: begin
               sum_q[id_q]    <= sum_d;
               sumsq_q[id_q]  <= sumsq_d;
               cnt_q[id_q]    <= cnt_d;
               vbit_q[addr_q] <= 1'b1;
               state_q        <= S_CALC;
            end
            S_CALC: begin
               valid_q  <= 1'b1;
               ostock_q <= id_q;
               ocnt_q   <= cur_cnt;
               osum_q   <= cur_sum;
               osq_q    <= cur_sq;
               ovar_q   <= var_d;
               state_q  <= S_OUT;
            end
            S_OUT:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/volatility_accum.md
Name: volatility_accum

Overview:
- Downstream consumer of the volatility write-address controller.
- Stores each incoming price into a shared per-stock circular price buffer at the supplied write address.
- Keeps running sum, sum-of-squares and fill count per stock, and emits the unnormalised variance numerator (N·Σp² − (Σp)²) for the updated stock.
- Feeds the quoting/spread stage. No divider; normalisation happens downstream.

Parameters:
- NUM_STOCKS, 4, number of instruments; sets stock-id width (clog2).
- BUFFER_SIZE, 20, price-history window per stock; entries per stock region.
- PRICE_WIDTH, 32, unsigned price width.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_addr_valid  in  1  write address, stock id and price are valid this cycle.
- i_write_address  in  clog2(NUM_STOCKS*BUFFER_SIZE)  absolute buffer address from the address controller.
- i_stock_id  in  clog2(NUM_STOCKS)  stock owning the sample.
- i_price  in  PRICE_WIDTH  unsigned sample.
- o_ready  out  1  block can accept a sample this cycle.
- o_valid  out  1  one-cycle pulse; result outputs valid.
- o_stock_id  out  clog2(NUM_STOCKS)  stock of the result.
- o_count  out  clog2(BUFFER_SIZE+1)  samples currently in the window (N).
- o_sum  out  PRICE_WIDTH+clog2(BUFFER_SIZE+1)  Σp over the window.
- o_sumsq  out  2*PRICE_WIDTH+clog2(BUFFER_SIZE+1)  Σp² over the window.
- o_var_num  out  2*PRICE_WIDTH+2*clog2(BUFFER_SIZE+1)  N·Σp² − (Σp)².
- o_addr_error  out  1  one-cycle pulse; sample rejected.

Behaviour:
- Reset, synchronous and active-high:
  - state = IDLE, o_ready = 1.
  - o_valid, o_addr_error, o_stock_id, o_count, o_sum, o_sumsq and o_var_num all 0.
  - All per-stock count, sum and sumsq registers cleared.
  - All NUM_STOCKS*BUFFER_SIZE entry-valid bits cleared.
  - Price RAM contents are not cleared. Entries with a clear valid bit read as 0.
- Handshake:
  - Accept when i_addr_valid && o_ready on a rising edge.
  - o_ready = (state == IDLE).
  - i_addr_valid while o_ready = 0 is ignored; no buffering, no error.
- Address check at accept:
  - Legal requires i_stock_id < NUM_STOCKS and BUFFER_SIZE*id ≤ i_write_address ≤ BUFFER_SIZE*id + BUFFER_SIZE − 1.
  - If illegal: o_addr_error = 1 for the cycle after the accept edge. State stays IDLE and no storage changes.
- FSM: IDLE → LOAD → ACC → CALC → OUT → IDLE, one cycle per state.
  - IDLE: latch address, id and price on accept.
  - LOAD: read old = valid_bit[addr] ? mem[addr] : 0.
  - ACC:
    - sum[id] += price − old; sumsq[id] += price² − old².
    - If the valid bit was clear, count[id] += 1; count saturates at BUFFER_SIZE.
    - Write mem[addr] = price and set valid_bit[addr].
  - CALC: compute count·sumsq and sum² (registered).
  - OUT:
    - o_valid = 1 for exactly this cycle.
    - Drive o_var_num = count·sumsq − sum², plus o_count, o_sum, o_sumsq and o_stock_id.
    - Result outputs hold their values until the next OUT.
- Latency and throughput:
  - If the accept edge is E0, o_valid is high between E3 and E4, and o_ready is high again from E4.
  - Throughput is 1 sample per 5 cycles.
- Arithmetic:
  - All arithmetic is unsigned.
  - sum and sumsq never underflow, because the evicted value was previously added.
  - o_var_num ≥ 0 (Cauchy-Schwarz), so the subtraction never wraps.
- Overwrite: rewriting the same address evicts the old price. Count is unchanged once that entry is valid.
- Stock independence: an update touches only the id's registers. Other stocks' state holds.
- Reset mid-operation (any state): the block returns to IDLE and discards the in-flight sample. The next sample for any stock yields count = 1.

Test Plan:
- Reset then stock 0, addr 0 price 10, then addr 1 price 20 → second o_valid: count 2, sum 30, sumsq 500, var_num 100; o_valid exactly 4 cycles after each accept.
- Stock 1, addr 20 price 5 after the above → count 1, sum 5, sumsq 25, var_num 0; stock 0 totals unchanged on a later stock-0 update.
- Stock 2: twenty samples of 7 at addrs 40..59, then price 1 at addr 40 → count 20, sum 134, sumsq 932, var_num 684.
- Stock 3 with addr 5 → o_addr_error pulse one cycle later, no o_valid, stock 3 state still zero; i_addr_valid held during LOAD..OUT of a legal sample → ignored, exactly one o_valid.
- Assert i_reset during ACC of stock 0's first sample, release, send addr 0 price 9 → o_valid with count 1, sum 9, var_num 0; all outputs 0 while reset is held.
